// File: rtl/spi_tx_pkg.sv
// Shared widths, frame constants and FSM state encoding for the SPI transmit lane.
package spi_tx_pkg;

  localparam int ADD_W              = 16;
  localparam int DATA_W             = 12;
  localparam int FRAME_W            = 28;
  localparam int BITCNT_W           = 5;
  localparam int FRAME_HALF_PERIODS = 57;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_H,
    SHIFT_L,
    HOLD,
    GAP
  } state_t;

endpackage

// File: rtl/spi_tx_phase_tmr.sv
// Loadable down-counter with a zero flag; paces every SCLK half-period and the CS_n gap.
module spi_tx_phase_tmr #(
  parameter int W = 3
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_tx.sv
// SPI mode-0 master transmitter: one 28-bit {address, data} frame per accepted word, MSB first.
// Build option SPI_TX_MISO_CAP_EN captures the 12 data-phase MISO bits onto RdData.
//
// state   | meaning
// IDLE    | ready for a word, CS_n high
// SETUP   | CS_n low, first bit on MOSI, SCLK low
// SHIFT_H | SCLK high, slave samples MOSI
// SHIFT_L | SCLK low, next bit on MOSI
// HOLD    | last half-period with CS_n low
// GAP     | CS_n high before the next frame
module spi_tx
  import spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic              Cclk,
  input  logic              rstn,
  input  logic [ADD_W-1:0]  TxAdd,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxReady,
  output logic              TxBusy,
  output logic              TxDone,
  output logic [DATA_W-1:0] RdData,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_n
);

  localparam int TMR_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_DIV = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_GAP = TMR_W'(CS_GAP - 1);

  state_t              r_state;
  logic [FRAME_W-2:0]  r_shreg;
  logic [BITCNT_W-1:0] r_bitcnt;
  logic                r_sclk, r_mosi, r_csn, r_ready, r_busy, r_done;
  logic                w_accept, w_tmr_zero, w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;

  assign w_accept   = TxValid && r_ready;
  assign w_tmr_load = (r_state == IDLE) ? w_accept : w_tmr_zero;
  assign w_tmr_val  = (r_state == HOLD) ? TMR_GAP : TMR_DIV;

  spi_tx_phase_tmr #(.W(TMR_W)) u_phase_tmr (
    .i_clk  (Cclk),
    .i_rstn (rstn),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  // MOSI holds the current bit; r_shreg keeps only the bits still to be sent.
  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_csn    <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg  <= {TxAdd[ADD_W-2:0], TxData};
            r_mosi   <= TxAdd[ADD_W-1];
            r_bitcnt <= BITCNT_W'(FRAME_W - 1);
            r_csn    <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= SETUP;
          end else begin
            r_ready <= 1'b1;
          end
        end
        SETUP, SHIFT_L: begin
          if (w_tmr_zero) begin
            r_sclk  <= 1'b1;
            r_state <= SHIFT_H;
          end
        end
        SHIFT_H: begin
          if (w_tmr_zero) begin
            r_sclk <= 1'b0;
            if (r_bitcnt == '0) begin
              r_state <= HOLD;
            end else begin
              r_mosi   <= r_shreg[FRAME_W-2];
              r_shreg  <= {r_shreg[FRAME_W-3:0], 1'b0};
              r_bitcnt <= r_bitcnt - 1'b1;
              r_state  <= SHIFT_L;
            end
          end
        end
        HOLD: begin
          if (w_tmr_zero) begin
            r_csn   <= 1'b1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (w_tmr_zero) begin
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign TxReady = r_ready;
  assign TxBusy  = r_busy;
  assign TxDone  = r_done;
  assign SCLK    = r_sclk;
  assign MOSI    = r_mosi;
  assign CS_n    = r_csn;

`ifdef SPI_TX_MISO_CAP_EN
  logic [DATA_W-1:0] r_cap, r_rddata;
  logic              w_rise, w_frame_end;

  // Rising edges are the SETUP/SHIFT_L exits; bitcnt already names the bit being sampled.
  assign w_rise      = w_tmr_zero && ((r_state == SETUP) || (r_state == SHIFT_L));
  assign w_frame_end = w_tmr_zero && (r_state == HOLD);

  always_ff @(posedge Cclk) begin
    if (!rstn) begin
      r_cap    <= '0;
      r_rddata <= '0;
    end else begin
      if (w_rise && (r_bitcnt < BITCNT_W'(DATA_W))) begin
        r_cap <= {r_cap[DATA_W-2:0], MISO};
      end
      if (w_frame_end) begin
        r_rddata <= r_cap;
      end
    end
  end

  assign RdData = r_rddata;
`else
  logic w_miso_unused;
  assign w_miso_unused = MISO;
  assign RdData        = '0;
`endif

endmodule

// File: tb/tb_spi_tx.sv
// Directed bench for spi_tx: two instances (CLK_DIV=4 and CLK_DIV=2) with a SPI slave model on the first.
module tb_spi_tx;

  localparam int DIV_A = 4;
  localparam int GAP_A = 2;
  localparam int DIV_B = 2;
  localparam int GAP_B = 2;
`ifdef SPI_TX_MISO_CAP_EN
  localparam logic [11:0] EXP_RD = 12'h3C7;
`else
  localparam logic [11:0] EXP_RD = 12'h000;
`endif

  logic Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  logic        rstn = 1'b0;
  logic [15:0] TxAdd = '0;
  logic [11:0] TxData = '0;
  logic        TxValid = 1'b0;
  logic        MISO = 1'b0;
  logic        TxReady, TxBusy, TxDone, SCLK, MOSI, CS_n;
  logic [11:0] RdData;

  logic [15:0] b_TxAdd = '0;
  logic [11:0] b_TxData = '0;
  logic        b_TxValid = 1'b0;
  logic        b_MISO = 1'b0;
  logic        b_TxReady, b_TxBusy, b_TxDone, b_SCLK, b_MOSI, b_CS_n;
  logic [11:0] b_RdData;

  spi_tx #(.CLK_DIV(DIV_A), .CS_GAP(GAP_A)) u_dut (
    .Cclk(Cclk), .rstn(rstn), .TxAdd(TxAdd), .TxData(TxData), .TxValid(TxValid),
    .TxReady(TxReady), .TxBusy(TxBusy), .TxDone(TxDone), .RdData(RdData),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .CS_n(CS_n)
  );

  spi_tx #(.CLK_DIV(DIV_B), .CS_GAP(GAP_B)) u_dut_div2 (
    .Cclk(Cclk), .rstn(rstn), .TxAdd(b_TxAdd), .TxData(b_TxData), .TxValid(b_TxValid),
    .TxReady(b_TxReady), .TxBusy(b_TxBusy), .TxDone(b_TxDone), .RdData(b_RdData),
    .SCLK(b_SCLK), .MOSI(b_MOSI), .MISO(b_MISO), .CS_n(b_CS_n)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge Cclk) cyc <= cyc + 1;

  // Slave model: decodes each CS_n window, answers 12'h3C7 on MISO during the data bits.
  logic [27:0] m_sr = '0;
  int          m_edges = 0, m_low = 0, m_hi = 0, done_cnt = 0, rdy_bad = 0;
  logic        m_psclk = 1'b0, m_pcsn = 1'b1;
  logic [11:0] miso_word = 12'h3C7;
  logic [27:0] q_bits[$];
  int          q_edges[$], q_low[$], q_gap[$], q_done[$];
  logic [11:0] q_rd[$];

  always @(negedge Cclk) begin
    if (!rstn) begin
      m_sr = '0; m_edges = 0; m_low = 0; m_hi = 0; MISO = 1'b0;
    end else begin
      if (TxDone) begin
        done_cnt++;
        q_done.push_back(cyc);
        q_rd.push_back(RdData);
      end
      if (TxReady && (!CS_n || TxBusy)) rdy_bad++;
      if (!CS_n) begin
        if (m_pcsn) q_gap.push_back(m_hi);
        m_low++;
        if (SCLK && !m_psclk) begin
          m_sr = {m_sr[26:0], MOSI};
          m_edges++;
          MISO = (m_edges >= 16 && m_edges < 28) ? miso_word[27 - m_edges] : 1'b0;
        end
      end else begin
        if (!m_pcsn) begin
          q_bits.push_back(m_sr);
          q_edges.push_back(m_edges);
          q_low.push_back(m_low);
          m_sr = '0; m_edges = 0; m_low = 0; m_hi = 0; MISO = 1'b0;
        end
        m_hi++;
      end
    end
    m_psclk = SCLK;
    m_pcsn  = CS_n;
  end

  task automatic clear_model();
    q_bits.delete(); q_edges.delete(); q_low.delete(); q_gap.delete();
    q_done.delete(); q_rd.delete();
    done_cnt = 0; rdy_bad = 0;
  endtask

  task automatic send_a(input logic [15:0] a, input logic [11:0] d, output int acc, output bit ok);
    @(negedge Cclk); #1;
    TxAdd = a; TxData = d; TxValid = 1'b1; ok = 1'b0; acc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (TxReady) begin acc = cyc; ok = 1'b1; break; end
      @(negedge Cclk); #1;
    end
    @(negedge Cclk); #1;
    TxValid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && q_bits.size() < n; i++) @(negedge Cclk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Cclk);
    n_total++; if (CS_n !== 1'b1) $display("FAIL reset_csn got %b want 1", CS_n); else n_pass++;
    n_total++; if (SCLK !== 1'b0) $display("FAIL reset_sclk got %b want 0", SCLK); else n_pass++;
    n_total++; if (MOSI !== 1'b0) $display("FAIL reset_mosi got %b want 0", MOSI); else n_pass++;
    n_total++; if (TxReady !== 1'b0) $display("FAIL reset_ready got %b want 0", TxReady); else n_pass++;
    n_total++; if (TxBusy !== 1'b0 || TxDone !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", TxBusy, TxDone); else n_pass++;
    n_total++; if (RdData !== 12'h000) $display("FAIL reset_rddata got %h want 000", RdData); else n_pass++;
    #1 rstn = 1'b1;
    @(negedge Cclk);
    n_total++; if (TxReady !== 1'b1) $display("FAIL ready_after_reset got %b want 1", TxReady); else n_pass++;
  endtask

  task automatic test_single_word();
    int acc; bit ok;
    clear_model();
    send_a(16'h0001, 12'hA5C, acc, ok);
    n_total++; if (!ok) $display("FAIL single_accept timed out"); else n_pass++;
    wait_frames(1, 400);
    repeat (5) @(negedge Cclk);
    n_total++; if (q_bits.size() != 1) $display("FAIL single_frames got %0d want 1", q_bits.size()); else n_pass++;
    n_total++; if (q_bits[0] !== 28'h0001A5C) $display("FAIL single_bits got %h want 0001a5c", q_bits[0]); else n_pass++;
    n_total++; if (q_edges[0] != 28) $display("FAIL single_edges got %0d want 28", q_edges[0]); else n_pass++;
    n_total++; if (q_low[0] != 57 * DIV_A) $display("FAIL single_cs_low got %0d want %0d", q_low[0], 57 * DIV_A); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL single_done_count got %0d want 1", done_cnt); else n_pass++;
    n_total++; if (q_done[0] - acc != 1 + 57 * DIV_A) $display("FAIL single_done_latency got %0d want %0d", q_done[0] - acc, 1 + 57 * DIV_A); else n_pass++;
    n_total++; if (q_rd[0] !== EXP_RD) $display("FAIL single_rddata got %h want %h", q_rd[0], EXP_RD); else n_pass++;
  endtask

  task automatic test_ignore_midframe();
    int acc; bit ok;
    clear_model();
    send_a(16'h1234, 12'h0F0, acc, ok);
    n_total++; if (!ok) $display("FAIL ignore_accept timed out"); else n_pass++;
    repeat (60) @(negedge Cclk);
    #1;
    TxAdd = 16'hBEEF; TxData = 12'hABC; TxValid = 1'b1;
    n_total++; if (TxReady !== 1'b0) $display("FAIL ignore_ready got %b want 0", TxReady); else n_pass++;
    n_total++; if (TxBusy !== 1'b1) $display("FAIL ignore_busy got %b want 1", TxBusy); else n_pass++;
    @(negedge Cclk); #1;
    TxValid = 1'b0;
    wait_frames(1, 400);
    repeat (300) @(negedge Cclk);
    n_total++; if (q_bits.size() != 1) $display("FAIL ignore_frames got %0d want 1", q_bits.size()); else n_pass++;
    n_total++; if (q_bits[0] !== 28'h12340F0) $display("FAIL ignore_bits got %h want 12340f0", q_bits[0]); else n_pass++;
    n_total++; if (done_cnt != 1) $display("FAIL ignore_done_count got %0d want 1", done_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] adds [3] = '{16'd0, 16'd1, 16'd2};
    logic [11:0] dats [3] = '{12'h123, 12'h456, 12'h789};
    logic [27:0] exp_f [3] = '{28'h0000123, 28'h0001456, 28'h0002789};
    int acc [3];
    bit got;
    clear_model();
    @(negedge Cclk); #1;
    TxValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      TxAdd = adds[k]; TxData = dats[k]; got = 1'b0; acc[k] = 0;
      for (int i = 0; i < 1000; i++) begin
        if (TxReady) begin acc[k] = cyc; got = 1'b1; break; end
        @(negedge Cclk); #1;
      end
      n_total++; if (!got) $display("FAIL b2b_accept_%0d timed out", k); else n_pass++;
      @(negedge Cclk); #1;
    end
    TxValid = 1'b0;
    wait_frames(3, 1000);
    repeat (5) @(negedge Cclk);
    for (int k = 0; k < 3; k++) begin
      n_total++; if (q_bits[k] !== exp_f[k]) $display("FAIL b2b_bits_%0d got %h want %h", k, q_bits[k], exp_f[k]); else n_pass++;
    end
    // High time between frames is the GAP state plus the IDLE acceptance cycle.
    for (int k = 1; k < 3; k++) begin
      n_total++; if (q_gap[k] != GAP_A + 1) $display("FAIL b2b_gap_%0d got %0d want %0d", k, q_gap[k], GAP_A + 1); else n_pass++;
      n_total++; if (acc[k] - acc[k-1] != 57 * DIV_A + GAP_A + 1) $display("FAIL b2b_rate_%0d got %0d want %0d", k, acc[k] - acc[k-1], 57 * DIV_A + GAP_A + 1); else n_pass++;
    end
    n_total++; if (rdy_bad != 0) $display("FAIL b2b_ready_outside_idle got %0d want 0", rdy_bad); else n_pass++;
    n_total++; if (done_cnt != 3) $display("FAIL b2b_done_count got %0d want 3", done_cnt); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int acc; bit ok, hit;
    clear_model();
    send_a(16'h0ABC, 12'h5A5, acc, ok);
    n_total++; if (!ok) $display("FAIL rstmid_accept timed out"); else n_pass++;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge Cclk); #1;
      if (m_edges == 10) begin hit = 1'b1; break; end
    end
    n_total++; if (!hit) $display("FAIL rstmid_10th_edge timed out"); else n_pass++;
    rstn = 1'b0;
    @(negedge Cclk);
    n_total++; if (CS_n !== 1'b1 || SCLK !== 1'b0) $display("FAIL rstmid_pins got cs_n=%b sclk=%b want 1 0", CS_n, SCLK); else n_pass++;
    n_total++; if (TxBusy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", TxBusy); else n_pass++;
    repeat (2) @(negedge Cclk);
    #1 rstn = 1'b1;
    repeat (300) @(negedge Cclk);
    n_total++; if (done_cnt != 0 || q_bits.size() != 0) $display("FAIL rstmid_no_done got done=%0d frames=%0d want 0 0", done_cnt, q_bits.size()); else n_pass++;
    send_a(16'h0ABC, 12'h5A5, acc, ok);
    n_total++; if (!ok) $display("FAIL rstmid_reaccept timed out"); else n_pass++;
    wait_frames(1, 400);
    n_total++; if (q_bits[0] !== 28'h0ABC5A5 || q_edges[0] != 28) $display("FAIL rstmid_next_frame got %h/%0d want 0abc5a5/28", q_bits[0], q_edges[0]); else n_pass++;
  endtask

  task automatic test_div2();
    bit got = 1'b0, seen_low = 1'b0, fin = 1'b0;
    int low = 0, rises = 0, last_rise = -1, min_sp = 1000, max_sp = 0;
    int hi_run = 0, min_hi = 1000, max_hi = 0;
    logic [27:0] sr = '0;
    logic ps = 1'b0;
    @(negedge Cclk); #1;
    b_TxAdd = 16'h95FF; b_TxData = 12'hFFF; b_TxValid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (b_TxReady) begin got = 1'b1; break; end
      @(negedge Cclk); #1;
    end
    n_total++; if (!got) $display("FAIL div2_accept timed out"); else n_pass++;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(negedge Cclk);
      if (!b_CS_n) begin
        seen_low = 1'b1;
        low++;
        if (b_SCLK) begin
          hi_run++;
          if (!ps) begin
            rises++;
            sr = {sr[26:0], b_MOSI};
            if (last_rise >= 0) begin
              if (cyc - last_rise < min_sp) min_sp = cyc - last_rise;
              if (cyc - last_rise > max_sp) max_sp = cyc - last_rise;
            end
            last_rise = cyc;
          end
        end else if (ps) begin
          if (hi_run < min_hi) min_hi = hi_run;
          if (hi_run > max_hi) max_hi = hi_run;
          hi_run = 0;
        end
      end else if (seen_low) begin
        fin = 1'b1;
      end
      ps = b_SCLK;
      #1 b_TxValid = 1'b0;
    end
    n_total++; if (!fin) $display("FAIL div2_frame_end timed out"); else n_pass++;
    n_total++; if (low != 57 * DIV_B) $display("FAIL div2_cs_low got %0d want %0d", low, 57 * DIV_B); else n_pass++;
    n_total++; if (rises != 28) $display("FAIL div2_edges got %0d want 28", rises); else n_pass++;
    n_total++; if (sr !== 28'h95FFFFF) $display("FAIL div2_bits got %h want 95fffff", sr); else n_pass++;
    n_total++; if (min_sp != 2 * DIV_B || max_sp != 2 * DIV_B) $display("FAIL div2_period got %0d..%0d want %0d", min_sp, max_sp, 2 * DIV_B); else n_pass++;
    n_total++; if (min_hi != DIV_B || max_hi != DIV_B) $display("FAIL div2_high_time got %0d..%0d want %0d", min_hi, max_hi, DIV_B); else n_pass++;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();
    test_div2();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
